// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the load/store unit: funct3 access
//                codes, FSM state encoding, access-size decode helper and
//                the timeout counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // funct3 encodings for loads/stores
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Width of the bus-timeout counter (TIMEOUT_CYCLES is limited to 1..255)
    localparam int LSU_TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // Unsupported codes (011, 110, 111) behave as word accesses.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            LSU_B, LSU_BU: return SZ_BYTE;
            LSU_H, LSU_HU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Ready-handshaked data-memory bus between the load/store unit
//                (master) and data memory (slave).
//  Ports       : Mem_Req_o/Mem_We_o/Mem_Addr_o/Mem_Byte_En_o/Mem_WData_o
//                driven by the master; Mem_Ready_i/Mem_RData_i by the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;

    logic        Mem_Req_o;
    logic        Mem_We_o;
    logic [31:0] Mem_Addr_o;
    logic [3:0]  Mem_Byte_En_o;
    logic [31:0] Mem_WData_o;
    logic        Mem_Ready_i;
    logic [31:0] Mem_RData_i;

    modport master (
        output Mem_Req_o,
        output Mem_We_o,
        output Mem_Addr_o,
        output Mem_Byte_En_o,
        output Mem_WData_o,
        input  Mem_Ready_i,
        input  Mem_RData_i
    );

    modport slave (
        input  Mem_Req_o,
        input  Mem_We_o,
        input  Mem_Addr_o,
        input  Mem_Byte_En_o,
        input  Mem_WData_o,
        output Mem_Ready_i,
        output Mem_RData_i
    );

endinterface : load_store_unit_if
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load-data aligner. Picks the byte/half/word
//                at the given byte offset and sign- or zero-extends it.
//  Ports       : word_i   - raw 32-bit memory read word
//                offset_i - byte offset within the word (addr[1:0])
//                funct3_i - load size/sign code
//                data_o   - aligned, extended result
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word_i[{offset_i, 3'b000} +: 8];
        // Halves are only ever issued at offsets 0 or 2
        w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            LSU_B:   data_o = {{24{w_byte[7]}}, w_byte};
            LSU_BU:  data_o = {24'd0, w_byte};
            LSU_H:   data_o = {{16{w_half[15]}}, w_half};
            LSU_HU:  data_o = {16'd0, w_half};
            default: data_o = word_i;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Multi-cycle load/store unit. Captures the ALU effective
//                address, drives a ready-handshaked memory bus, aligns and
//                extends load data, builds store byte-enables, and reports
//                misaligned accesses and bus timeouts.
//  Ports       : clk, reset (async, active-low)
//                Start_i, Mem_Read_i, Mem_Write_i, Funct3_i, Address_i,
//                Store_Data_i            - access request from the core
//                Busy_o, Done_o, Load_Data_o, Misaligned_o, Bus_Error_o
//                                        - status/result to the core
//                bus                     - memory bus (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic                  Mem_Read_i,
    input  logic                  Mem_Write_i,
    input  logic [2:0]            Funct3_i,
    input  logic [DATA_WIDTH-1:0] Address_i,
    input  logic [DATA_WIDTH-1:0] Store_Data_i,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic [DATA_WIDTH-1:0] Load_Data_o,
    output logic                  Misaligned_o,
    output logic                  Bus_Error_o,
    load_store_unit_if.master     bus
);

    localparam logic [LSU_TIMEOUT_W-1:0] TO_LIMIT = LSU_TIMEOUT_W'(TIMEOUT_CYCLES);

    lsu_state_e               state_q, state_d;
    logic [LSU_TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                     misal_q, misal_d;
    logic                     berr_q, berr_d;
    logic [31:0]              load_data_q;
    logic [31:0]              addr_q;
    logic [1:0]               off_q;
    logic [2:0]               f3_q;
    logic                     we_q;
    logic [3:0]               be_q;
    logic [31:0]              wdata_q;

    logic                     w_capture;
    logic                     w_load_en;
    logic                     w_misaligned;
    logic [3:0]               w_be;
    logic [31:0]              w_wdata;
    logic [31:0]              w_aligned;
    lsu_size_e                w_size;
    logic [1:0]               w_off;

    // ------------------------------------------------------------------
    // Request decode: size, misalignment and store lane generation
    // ------------------------------------------------------------------
    always_comb begin
        w_size       = f3_size(Funct3_i);
        w_off        = Address_i[1:0];
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = Store_Data_i;
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{Store_Data_i[7:0]}};
            end
            SZ_HALF: begin
                w_misaligned = w_off[0];
                w_be         = 4'b0011 << w_off;
                w_wdata      = {2{Store_Data_i[15:0]}};
            end
            default: begin
                w_misaligned = (w_off != 2'b00);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        misal_d   = 1'b0;
        berr_d    = 1'b0;
        w_capture = 1'b0;
        w_load_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (Start_i) begin
                    if (!(Mem_Read_i || Mem_Write_i)) begin
                        state_d = ST_DONE;
                    end else if (w_misaligned) begin
                        state_d = ST_ERR;
                        misal_d = 1'b1;
                    end else begin
                        state_d   = ST_ACCESS;
                        w_capture = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // A ready on the final permitted cycle still completes;
                // the abort happens on the wait edge after the counter has
                // already reached the limit, so the request stays up for
                // TIMEOUT_CYCLES+1 cycles.
                if (bus.Mem_Ready_i) begin
                    state_d   = ST_DONE;
                    w_load_en = !we_q;
                end else if (cnt_q == TO_LIMIT) begin
                    state_d = ST_ERR;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + LSU_TIMEOUT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data alignment
    // ------------------------------------------------------------------
    load_align u_load_align (
        .word_i   (bus.Mem_RData_i),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .data_o   (w_aligned)
    );

    // ------------------------------------------------------------------
    // State, counter and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            misal_q     <= 1'b0;
            berr_q      <= 1'b0;
            load_data_q <= '0;
            addr_q      <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            misal_q <= misal_d;
            berr_q  <= berr_d;
            if (w_load_en) begin
                load_data_q <= w_aligned;
            end
            if (w_capture) begin
                addr_q  <= {Address_i[31:2], 2'b00};
                off_q   <= w_off;
                f3_q    <= Funct3_i;
                // Write wins when both directions are requested
                we_q    <= Mem_Write_i;
                be_q    <= w_be;
                wdata_q <= w_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registers
    // ------------------------------------------------------------------
    assign Busy_o       = (state_q != ST_IDLE);
    assign Done_o       = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign Misaligned_o = misal_q;
    assign Bus_Error_o  = berr_q;
    assign Load_Data_o  = load_data_q;

    assign bus.Mem_Req_o     = (state_q == ST_ACCESS);
    assign bus.Mem_We_o      = (state_q == ST_ACCESS) && we_q;
    assign bus.Mem_Addr_o    = addr_q;
    assign bus.Mem_Byte_En_o = be_q;
    assign bus.Mem_WData_o   = wdata_q;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Scoreboard testbench for load_store_unit. A driver issues
//                directed and random accesses and pushes the expected
//                response; a monitor compares bus activity and completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TO = 4;

    typedef struct {
        bit          has_bus;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          misal;
        bit          berr;
        logic [31:0] ld;
        int          start_cyc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Start_i = 1'b0;
    logic        Mem_Read_i = 1'b0;
    logic        Mem_Write_i = 1'b0;
    logic [2:0]  Funct3_i = 3'b000;
    logic [31:0] Address_i = '0;
    logic [31:0] Store_Data_i = '0;
    logic        Busy_o;
    logic        Done_o;
    logic [31:0] Load_Data_o;
    logic        Misaligned_o;
    logic        Bus_Error_o;

    load_store_unit_if bus ();

    load_store_unit #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset_n),
        .Start_i      (Start_i),
        .Mem_Read_i   (Mem_Read_i),
        .Mem_Write_i  (Mem_Write_i),
        .Funct3_i     (Funct3_i),
        .Address_i    (Address_i),
        .Store_Data_i (Store_Data_i),
        .Busy_o       (Busy_o),
        .Done_o       (Done_o),
        .Load_Data_o  (Load_Data_o),
        .Misaligned_o (Misaligned_o),
        .Bus_Error_o  (Bus_Error_o),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t exp_q[$];
    logic [31:0] ld_model = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference load result: shift the word down to the addressed byte and
    // interpret the low 1/2/4 bytes as signed or unsigned integers.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                             input logic [2:0] f3);
        longint v;
        v = longint'(w >> (8 * off));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v -= 256;   end
            3'b100: v = v % 256;
            3'b001: begin v = v % 65536; if (v >= 32768) v -= 65536; end
            3'b101: v = v % 65536;
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    function automatic int size_bytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    // Expected outcome of one access; also advances the load-result model.
    function automatic exp_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] sdata,
                                   input logic [31:0] rdata, input int waits);
        exp_t e;
        int   n;
        int   off;
        n   = size_bytes(f3);
        off = int'(addr % 4);
        e.has_bus = 0; e.we = 0; e.addr = '0; e.be = '0; e.wdata = '0;
        e.misal = 0; e.berr = 0; e.lat = 1; e.start_cyc = 0;
        if (rd || wr) begin
            if ((addr % n) != 0) begin
                e.misal = 1;
            end else begin
                e.has_bus = 1;
                e.we      = wr;
                e.addr    = addr - off;
                e.be      = 4'(((1 << n) - 1) << off);
                for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sdata[8*(i % n) +: 8];
                if (waits > TO) begin
                    e.berr = 1;
                    e.lat  = TO + 2;
                end else begin
                    e.lat = 2 + waits;
                    if (!wr) ld_model = ref_load(rdata, off, f3);
                end
            end
        end
        e.ld = ld_model;
        return e;
    endfunction

    task automatic wait_idle(input string name);
        int b;
        b = 0;
        while (Busy_o && b < 12) begin
            @(posedge clk); #1;
            b++;
        end
        if (Busy_o) fail_now({name, "_busy_timeout"});
    endtask

    // One access. waits > TO means the memory never answers.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int waits);
        exp_t e;
        int   lim;
        @(negedge clk);
        e = model(rd, wr, f3, addr, sdata, rdata, waits);
        e.start_cyc = cyc;
        exp_q.push_back(e);
        Start_i = 1'b1; Mem_Read_i = rd; Mem_Write_i = wr; Funct3_i = f3;
        Address_i = addr; Store_Data_i = sdata;
        // ready while idle must be ignored
        bus.Mem_Ready_i = 1'($urandom % 2); bus.Mem_RData_i = $urandom;
        @(posedge clk); #1;
        Start_i = 1'b0; bus.Mem_Ready_i = 1'b0;
        if (e.has_bus) begin
            lim = (waits > TO) ? TO + 1 : waits;
            for (int i = 0; i < lim; i++) begin
                // new requests while busy must be ignored
                Start_i = 1'($urandom % 2); Mem_Read_i = 1'($urandom % 2);
                Mem_Write_i = 1'($urandom % 2); Funct3_i = 3'($urandom % 8);
                Address_i = $urandom; Store_Data_i = $urandom;
                bus.Mem_RData_i = $urandom;
                @(posedge clk); #1;
            end
            Start_i = 1'b0;
            if (waits <= TO) begin
                bus.Mem_Ready_i = 1'b1; bus.Mem_RData_i = rdata;
                @(posedge clk); #1;
                bus.Mem_Ready_i = 1'b0; bus.Mem_RData_i = $urandom;
            end
        end
        wait_idle("access");
    endtask

    // Monitor: bus activity and completion against the scoreboard queue
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (bus.Mem_Req_o) begin
                if (exp_q.size() == 0) fail_now("req_without_access");
                else if (!exp_q[0].has_bus) fail_now("req_unexpected");
                else begin
                    chk("mem_addr", bus.Mem_Addr_o, exp_q[0].addr);
                    chk("mem_be", 32'(bus.Mem_Byte_En_o), 32'(exp_q[0].be));
                    chk("mem_we", 32'(bus.Mem_We_o), 32'(exp_q[0].we));
                    if (exp_q[0].we) chk("mem_wdata", bus.Mem_WData_o, exp_q[0].wdata);
                end
            end
            if (Done_o) begin
                if (exp_q.size() == 0) fail_now("done_unexpected");
                else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.start_cyc + e.lat));
                    chk("misaligned", 32'(Misaligned_o), 32'(e.misal));
                    chk("bus_error", 32'(Bus_Error_o), 32'(e.berr));
                    chk("load_data", Load_Data_o, e.ld);
                    chk("busy_at_done", 32'(Busy_o), 32'd1);
                end
            end else if (Misaligned_o || Bus_Error_o) begin
                fail_now("flag_without_done");
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Mem_Ready_i = 1'b0;
        bus.Mem_RData_i = '0;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(Busy_o), 32'd0);
        chk("rst_done", 32'(Done_o), 32'd0);
        chk("rst_req", 32'(bus.Mem_Req_o), 32'd0);
        chk("rst_load", Load_Data_o, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_access(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        do_access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 0);
        do_access(1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 1);
        do_access(0, 1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 3);
        do_access(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h1234_5678, 0);
        do_access(1, 0, 3'b001, 32'h0000_0201, 32'h0, 32'h1234_5678, 0);
        do_access(1, 0, 3'b010, 32'h0000_0300, 32'h0, 32'h1111_1111, TO + 1);
        do_access(1, 0, 3'b010, 32'h0000_0304, 32'h0, 32'hCAFE_F00D, TO);
        do_access(0, 0, 3'b010, 32'h0000_0400, 32'h0, 32'h0, 0);
        do_access(1, 1, 3'b000, 32'h0000_0501, 32'h0000_005A, 32'h0, 2);
        do_access(1, 0, 3'b101, 32'h0000_0602, 32'h0, 32'h8001_7FFF, 0);
        do_access(1, 0, 3'b110, 32'h0000_0702, 32'h0, 32'h0, 0);

        // Reset asserted while the bus waits for ready
        @(negedge clk);
        begin
            exp_t e;
            e = model(1, 0, 3'b010, 32'h0000_0800, 32'h0, 32'h0, TO + 1);
            e.start_cyc = cyc;
            exp_q.push_back(e);
        end
        Start_i = 1'b1; Mem_Read_i = 1'b1; Mem_Write_i = 1'b0; Funct3_i = 3'b010;
        Address_i = 32'h0000_0800;
        @(posedge clk); #1;
        Start_i = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(bus.Mem_Req_o), 32'd0);
        chk("async_rst_busy", 32'(Busy_o), 32'd0);
        chk("async_rst_load", Load_Data_o, 32'd0);
        chk("async_rst_addr", bus.Mem_Addr_o, 32'd0);
        exp_q.delete();
        ld_model = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_busy", 32'(Busy_o), 32'd0);
        @(posedge clk); #1;

        // Random accesses
        for (int k = 0; k < 200; k++) begin
            bit          rd, wr;
            logic [31:0] a;
            rd = 0; wr = 0;
            if (($urandom % 8) != 0) begin
                rd = 1'($urandom % 2);
                wr = 1'($urandom % 2);
                if (!rd && !wr) rd = 1;
            end
            a = {20'h0, 12'($urandom)};
            do_access(rd, wr, 3'($urandom % 8), a, $urandom, $urandom,
                      int'($urandom % (TO + 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_load_store_unit
`default_nettype wire
